// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and default timing constants for the button
//                impulse generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  // Pulse-generator states: released, held (waiting for first repeat), repeating
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // Defaults sized for a 100 MHz clock
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms

  // Larger of two integers, used to size the shared repeat counter
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_filter
//  Description : Synchronises an asynchronous button pin, corrects its
//                polarity, and only accepts a level change once the new level
//                has been stable for DEBOUNCE_CYCLES. Provides the debounced
//                level plus single-cycle rise/fall strobes that are valid in
//                the cycle before the level register changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int   c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  // Pin value that means "not pressed"; the chain resets to it
  localparam logic c_released = (BTN_ACTIVE_LOW != 0);

  // Parameter sanity checks at elaboration
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debounce_filter: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("debounce_filter: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_level;
  logic                   w_pressed;
  logic                   w_diff;
  logic                   w_done;

  // Synchroniser chain, reset to the released pin value
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync <= {SYNC_STAGES{c_released}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign w_pressed = r_sync[SYNC_STAGES-1] ^ c_released;
  assign w_diff    = (w_pressed != r_level);
  // Counter saturates at DEBOUNCE_CYCLES; the next differing cycle commits
  assign w_done    = w_diff && (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES));

  // Stable-time counter and debounced level register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_diff || w_done) begin
      r_cnt   <= '0;
      r_level <= r_level ^ w_done;
    end else begin
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  assign level = r_level;
  assign rise  = w_done & ~r_level;
  assign fall  = w_done &  r_level;

endmodule
`default_nettype wire

// File: rtl/button_impulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_impulse_gen
//  Description : Converts a raw bouncing push-button into clean single-cycle
//                impulse strobes: one per press, with optional auto-repeat
//                (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD)
//                while the button stays held and repeat_en is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_impulse_gen
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic impulse,
  output logic btn_level
);

  localparam int c_rpt_max = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int c_rpt_w   = (c_rpt_max > 1) ? $clog2(c_rpt_max) : 1;
  localparam logic [c_rpt_w-1:0] c_delay_last  = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(REPEAT_PERIOD - 1);

  // Parameter sanity checks at elaboration
  if (REPEAT_DELAY < 1) begin : g_chk_delay
    $error("button_impulse_gen: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_chk_period
    $error("button_impulse_gen: REPEAT_PERIOD must be >= 1");
  end

  btn_state_t         r_state;
  btn_state_t         w_state_nxt;
  logic [c_rpt_w-1:0] r_cnt;
  logic [c_rpt_w-1:0] w_cnt_nxt;
  logic               r_impulse;
  logic               w_impulse_nxt;
  logic               w_due;
  logic               w_rise;
  logic               w_fall;

  debounce_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk    (clk),
    .nrst   (nrst),
    .btn_in (btn_in),
    .level  (btn_level),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  // State register, repeat counter and impulse register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_impulse <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_impulse <= w_impulse_nxt;
    end
  end

  // Next state, repeat timing and impulse; release beats a due repeat pulse
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_due       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!repeat_en) begin
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_delay_last) begin
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
          w_due       = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_rpt_w'(1);
        end
      end
      REPEAT: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!repeat_en) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_period_last) begin
          w_cnt_nxt   = '0;
          w_due       = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_rpt_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Press pulse only from IDLE; the r_impulse guard keeps strobes apart
    // even with a delay or period of one cycle
    w_impulse_nxt = ((r_state == IDLE) && w_rise) || (w_due && !r_impulse);
  end

  assign impulse = r_impulse;

endmodule
`default_nettype wire

// File: tb/tb_button_impulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_impulse_gen
//  Description : Self-checking bench for button_impulse_gen with short timing
//                parameters (sync 2, debounce 4, delay 20, period 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_impulse_gen;
  import btn_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  logic btn_in;
  logic repeat_en;
  logic impulse;
  logic btn_level;

  button_impulse_gen #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .BTN_ACTIVE_LOW  (0)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .impulse   (impulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int   at;
    logic val;
  } lvl_exp_t;

  typedef struct {
    int hold;
    bit ren;
    int drop;
    int n;
    int off [4];
  } press_vec_t;

  int       imp_q [$];
  lvl_exp_t lvl_q [$];
  int       n_vec = 0;
  int       n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score every expectation due there
  task automatic tick();
    lvl_exp_t e;
    @(negedge clk);
    if (imp_q.size() > 0 && imp_q[0] == edge_n) begin
      void'(imp_q.pop_front());
      check($sformatf("impulse@%0d", edge_n), 32'(impulse), 32'd1);
    end else if (impulse !== 1'b0) begin
      check($sformatf("impulse@%0d", edge_n), 32'(impulse), 32'd0);
    end
    while (lvl_q.size() > 0 && lvl_q[0].at <= edge_n) begin
      e = lvl_q.pop_front();
      check($sformatf("btn_level@%0d", e.at), 32'(btn_level), 32'(e.val));
    end
  endtask

  task automatic wait_to(input int n);
    while (edge_n < n) tick();
  endtask

  function automatic press_vec_t mk(input int h, input bit r, input int d, input int n,
                                    input int o0, input int o1, input int o2, input int o3);
    press_vec_t v;
    v.hold = h; v.ren = r; v.drop = d; v.n = n;
    v.off[0] = o0; v.off[1] = o1; v.off[2] = o2; v.off[3] = o3;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    press_vec_t vecs [4];
    int p;
    int e;

    // Clean presses: hold length, repeat_en, drop offset, impulse offsets from first sampled edge
    vecs[0] = mk(15, 1'b0, -1, 1, 6, 0, 0, 0);
    vecs[1] = mk(60, 1'b1, 46, 4, 6, 26, 34, 42);
    vecs[2] = mk(40, 1'b1, -1, 4, 6, 26, 34, 42);
    vecs[3] = mk(7,  1'b1, -1, 1, 6, 0, 0, 0);

    nrst = 1'b0; btn_in = 1'b0; repeat_en = 1'b0;
    repeat (3) tick();
    check("reset_impulse", 32'(impulse), 32'd0);
    check("reset_level", 32'(btn_level), 32'd0);
    check("reset_state", 32'(dut.r_state), 32'(IDLE));
    nrst = 1'b1;
    repeat (3) tick();

    for (int k = 0; k < 4; k++) begin
      p = edge_n + 1;
      for (int j = 0; j < vecs[k].n; j++) imp_q.push_back(p + vecs[k].off[j]);
      lvl_q.push_back('{at: p + 5, val: 1'b0});
      lvl_q.push_back('{at: p + 6, val: 1'b1});
      lvl_q.push_back('{at: p + vecs[k].hold + 5, val: 1'b1});
      lvl_q.push_back('{at: p + vecs[k].hold + 6, val: 1'b0});
      btn_in = 1'b1;
      repeat_en = vecs[k].ren;
      if (vecs[k].drop >= 0) begin
        wait_to(p + vecs[k].drop - 1);
        repeat_en = 1'b0;
      end
      wait_to(p + vecs[k].hold - 1);
      btn_in = 1'b0;
      wait_to(p + vecs[k].hold + 20);
      repeat_en = 1'b0;
    end

    // Bounce: 3 high / 1 low for 20 cycles, then steady high
    p = edge_n + 1;
    imp_q.push_back(p + 26);
    lvl_q.push_back('{at: p + 25, val: 1'b0});
    lvl_q.push_back('{at: p + 26, val: 1'b1});
    lvl_q.push_back('{at: p + 35, val: 1'b1});
    lvl_q.push_back('{at: p + 36, val: 1'b0});
    for (int i = 0; i < 30; i++) begin
      btn_in = (i >= 20) || ((i % 4) != 3);
      tick();
    end
    btn_in = 1'b0;
    wait_to(p + 50);

    // Glitch: 3 cycles high never reaches the debounced level
    p = edge_n + 1;
    lvl_q.push_back('{at: p + 4, val: 1'b0});
    lvl_q.push_back('{at: p + 6, val: 1'b0});
    lvl_q.push_back('{at: p + 8, val: 1'b0});
    btn_in = 1'b1;
    wait_to(p + 2);
    btn_in = 1'b0;
    wait_to(p + 20);

    // Release lands on the cycle the second repeat pulse is due
    p = edge_n + 1;
    imp_q.push_back(p + 6);
    imp_q.push_back(p + 26);
    lvl_q.push_back('{at: p + 33, val: 1'b1});
    lvl_q.push_back('{at: p + 34, val: 1'b0});
    btn_in = 1'b1; repeat_en = 1'b1;
    wait_to(p + 27);
    btn_in = 1'b0;
    wait_to(p + 33);
    check("pre_release_state", 32'(dut.r_state), 32'(REPEAT));
    wait_to(p + 34);
    check("release_state", 32'(dut.r_state), 32'(IDLE));
    wait_to(p + 50);
    repeat_en = 1'b0;

    // Reset during REPEAT with the button held, then a fresh press
    p = edge_n + 1;
    imp_q.push_back(p + 6);
    imp_q.push_back(p + 26);
    lvl_q.push_back('{at: p + 5, val: 1'b0});
    lvl_q.push_back('{at: p + 6, val: 1'b1});
    btn_in = 1'b1; repeat_en = 1'b1;
    wait_to(p + 33);
    @(posedge clk); #1;
    check("pre_rst_impulse", 32'(impulse), 32'd1);
    check("pre_rst_level", 32'(btn_level), 32'd1);
    nrst = 1'b0;
    #1;
    check("async_rst_impulse", 32'(impulse), 32'd0);
    check("async_rst_level", 32'(btn_level), 32'd0);
    repeat (3) tick();
    nrst = 1'b1;
    e = edge_n + 1;
    imp_q.push_back(e + 6);
    imp_q.push_back(e + 26);
    imp_q.push_back(e + 34);
    lvl_q.push_back('{at: e + 5, val: 1'b0});
    lvl_q.push_back('{at: e + 6, val: 1'b1});
    lvl_q.push_back('{at: e + 34, val: 1'b1});
    lvl_q.push_back('{at: e + 35, val: 1'b0});
    wait_to(e + 28);
    btn_in = 1'b0;
    wait_to(e + 50);
    repeat_en = 1'b0;

    // Anything still queued was never observed
    while (imp_q.size() > 0) begin
      check($sformatf("impulse_pending@%0d", imp_q[0]), 32'd0, 32'd1);
      void'(imp_q.pop_front());
    end
    while (lvl_q.size() > 0) begin
      check($sformatf("btn_level_pending@%0d", lvl_q[0].at), 32'd0, 32'd1);
      void'(lvl_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
